regfile_onehot_wr: RTL and testbench



---
 rtl/regfile_onehot_wr.sv | 107 ++++++++++
 tb/tb_regfile_onehot_wr.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_onehot_wr.sv
// regfile_onehot_wr
//   Dual-read, single-write register file: 32 entries x WIDTH bits, written
//   through a one-hot enable vector that comes straight from the 5-to-32
//   write-select decoder. Entry ZERO_REG always reads as zero. A write vector
//   with two or more bits set is suppressed and flagged on wr_err.
//
// Ports
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   wr_onehot  in   [31:0] write enables, one bit per register (all zero = idle)
//   wr_data    in   [WIDTH-1:0] write data
//   rd_sel_a   in   [4:0] read port A index
//   rd_sel_b   in   [4:0] read port B index
//   rd_data_a  out  [WIDTH-1:0] read port A data (combinational, write-through)
//   rd_data_b  out  [WIDTH-1:0] read port B data (combinational, write-through)
//   wr_err     out  registered: previous cycle's wr_onehot was multi-hot
//   wr_count   out  [15:0] registered count of committed writes, wraps
module regfile_onehot_wr #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      wr_onehot,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [4:0]       rd_sel_a,
    input  logic [4:0]       rd_sel_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             wr_err,
    output logic [15:0]      wr_count
);

    localparam logic [4:0] ZSEL = 5'(ZERO_REG);

    logic [WIDTH-1:0] regs_q [32];
    logic [WIDTH-1:0] regs_d [32];
    logic             wr_err_q,   wr_err_d;
    logic [15:0]      wr_count_q, wr_count_d;

    logic wr_multi;
    logic wr_legal;

    // x & (x-1) clears the lowest set bit; anything left means two or more bits.
    always_comb begin
        wr_multi = |(wr_onehot & (wr_onehot - 32'd1));
        wr_legal = (|wr_onehot) && !wr_multi;
    end

    always_comb begin
        for (int unsigned i = 0; i < 32; i++) begin
            regs_d[5'(i)] = regs_q[5'(i)];
            if (wr_legal && wr_onehot[5'(i)] && (5'(i) != ZSEL)) begin
                regs_d[5'(i)] = wr_data;
            end
        end
        // The zero entry is never loaded, so it stays at its reset value.
        regs_d[ZSEL] = '0;

        wr_err_d   = wr_multi;
        wr_count_d = wr_count_q;
        if (wr_legal && !wr_onehot[ZSEL]) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[5'(i)] <= '0;
            end
            wr_err_q   <= 1'b0;
            wr_count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[5'(i)] <= regs_d[5'(i)];
            end
            wr_err_q   <= wr_err_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Same-cycle legal writes bypass to the read ports; multi-hot never does.
    always_comb begin
        rd_data_a = '0;
        if (rd_sel_a != ZSEL) begin
            if (wr_legal && wr_onehot[rd_sel_a]) begin
                rd_data_a = wr_data;
            end else begin
                rd_data_a = regs_q[rd_sel_a];
            end
        end

        rd_data_b = '0;
        if (rd_sel_b != ZSEL) begin
            if (wr_legal && wr_onehot[rd_sel_b]) begin
                rd_data_b = wr_data;
            end else begin
                rd_data_b = regs_q[rd_sel_b];
            end
        end
    end

    assign wr_err   = wr_err_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// tb_regfile_onehot_wr
//   Directed bench for regfile_onehot_wr. Expected values are pushed to a
//   scoreboard queue as stimulus is driven and popped/compared once the DUT
//   output they refer to is valid.
module tb_regfile_onehot_wr;

    logic        clock;
    logic        reset_n;
    logic [31:0] wr_onehot;
    logic [63:0] wr_data;
    logic [4:0]  rd_sel_a;
    logic [4:0]  rd_sel_b;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic        wr_err;
    logic [15:0] wr_count;

    regfile_onehot_wr #(.WIDTH(64), .ZERO_REG(31)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_onehot (wr_onehot),
        .wr_data   (wr_data),
        .rd_sel_a  (rd_sel_a),
        .rd_sel_b  (rd_sel_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_err    (wr_err),
        .wr_count  (wr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Which DUT output an expectation refers to.
    localparam int unsigned SRC_A   = 0;
    localparam int unsigned SRC_B   = 1;
    localparam int unsigned SRC_ERR = 2;
    localparam int unsigned SRC_CNT = 3;

    typedef struct {
        string       tag;
        int unsigned src;
        logic [63:0] exp;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [15:0] exp_count = '0;

    function automatic logic [63:0] observe(input int unsigned src);
        case (src)
            SRC_A:   return rd_data_a;
            SRC_B:   return rd_data_b;
            SRC_ERR: return {63'd0, wr_err};
            default: return {48'd0, wr_count};
        endcase
    endfunction

    task automatic push(input string tag, input int unsigned src, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.src = src;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.src);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr_t(input int unsigned idx, input logic [63:0] d);
        tick();
        wr_onehot = 32'd1 << idx;
        wr_data   = d;
        if (idx != 31) exp_count = exp_count + 16'd1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b1;
        wr_onehot = '0;
        wr_data   = '0;
        rd_sel_a  = 5'd0;
        rd_sel_b  = 5'd1;
        #1;
        reset_n = 1'b0;
        #2;
        push("reset_rd_a", SRC_A, 64'd0);
        push("reset_rd_b", SRC_B, 64'd0);
        push("reset_err", SRC_ERR, 64'd0);
        push("reset_cnt", SRC_CNT, 64'd0);
        check_all();
        tick();
        tick();
        reset_n = 1'b1;

        // Basic write with same-cycle bypass, then stored value.
        tick();
        wr_onehot = 32'd1 << 5;
        wr_data   = 64'h0123_4567_89AB_CDEF;
        rd_sel_a  = 5'd5;
        exp_count = exp_count + 16'd1;
        #3;
        push("basic_bypass", SRC_A, 64'h0123_4567_89AB_CDEF);
        push("basic_cnt_before", SRC_CNT, 64'd0);
        check_all();
        tick();
        wr_onehot = '0;
        wr_data   = '0;
        #3;
        push("basic_stored", SRC_A, 64'h0123_4567_89AB_CDEF);
        push("basic_cnt", SRC_CNT, 64'd1);
        push("basic_err", SRC_ERR, 64'd0);
        check_all();

        // Zero register write is discarded and not counted.
        tick();
        wr_onehot = 32'h8000_0000;
        wr_data   = '1;
        rd_sel_b  = 5'd31;
        #3;
        push("zero_same_cycle", SRC_B, 64'd0);
        check_all();
        tick();
        wr_onehot = '0;
        #3;
        push("zero_next_cycle", SRC_B, 64'd0);
        push("zero_cnt", SRC_CNT, 64'd1);
        push("zero_err", SRC_ERR, 64'd0);
        check_all();

        // Multi-hot write: suppressed, no bypass, single-cycle error pulse.
        wr_t(3, 64'hA);
        wr_t(4, 64'hB);
        tick();
        wr_onehot = 32'h0000_0018;
        wr_data   = 64'hDEAD;
        rd_sel_a  = 5'd3;
        rd_sel_b  = 5'd4;
        #3;
        push("multi_nobypass_a", SRC_A, 64'hA);
        push("multi_nobypass_b", SRC_B, 64'hB);
        push("multi_err_before", SRC_ERR, 64'd0);
        check_all();
        tick();
        wr_onehot = '0;
        #3;
        push("multi_keep_a", SRC_A, 64'hA);
        push("multi_keep_b", SRC_B, 64'hB);
        push("multi_err", SRC_ERR, 64'd1);
        push("multi_cnt", SRC_CNT, {48'd0, exp_count});
        check_all();
        tick();
        #3;
        push("multi_err_clear", SRC_ERR, 64'd0);
        check_all();

        // Back-to-back illegal cycles keep wr_err high.
        tick();
        wr_onehot = 32'h0000_0003;
        wr_data   = 64'h5555;
        rd_sel_a  = 5'd0;
        tick();
        #3;
        push("multi2_err1", SRC_ERR, 64'd1);
        push("multi2_rd0", SRC_A, 64'd0);
        check_all();
        tick();
        wr_onehot = '0;
        #3;
        push("multi2_err2", SRC_ERR, 64'd1);
        check_all();
        tick();
        #3;
        push("multi2_err_clear", SRC_ERR, 64'd0);
        push("multi2_cnt", SRC_CNT, 64'd3);
        check_all();

        // Reset asserted mid-run while a write is being driven.
        tick();
        wr_onehot = 32'd1 << 7;
        wr_data   = 64'h77;
        rd_sel_a  = 5'd3;
        rd_sel_b  = 5'd4;
        #2;
        reset_n = 1'b0;
        #1;
        push("midrst_rd_a", SRC_A, 64'd0);
        push("midrst_rd_b", SRC_B, 64'd0);
        push("midrst_err", SRC_ERR, 64'd0);
        push("midrst_cnt", SRC_CNT, 64'd0);
        check_all();
        tick();
        #3;
        push("midrst_cnt_held", SRC_CNT, 64'd0);
        check_all();
        wr_onehot = '0;
        tick();
        reset_n  = 1'b1;
        rd_sel_a = 5'd7;
        exp_count = '0;
        #3;
        push("midrst_reg7", SRC_A, 64'd0);
        push("midrst_cnt_after", SRC_CNT, 64'd0);
        check_all();

        // Fill every register, then sweep both ports.
        for (int unsigned i = 0; i < 31; i++) begin
            wr_t(i, 64'(i * 32'h1111));
        end
        tick();
        wr_onehot = '0;
        wr_data   = '0;
        #3;
        push("sweep_cnt", SRC_CNT, 64'd31);
        check_all();
        for (int unsigned i = 0; i < 32; i++) begin
            rd_sel_a = 5'(i);
            rd_sel_b = 5'(i);
            #1;
            push($sformatf("sweep_a%0d", i), SRC_A, (i == 31) ? 64'd0 : 64'(i * 32'h1111));
            push($sformatf("sweep_b%0d", i), SRC_B, (i == 31) ? 64'd0 : 64'(i * 32'h1111));
            check_all();
        end

        // Counter wrap: drive up to 0xFFFF, then one more write wraps to 0.
        rd_sel_a = 5'd1;
        for (int unsigned n = 0; n < 65504; n++) begin
            wr_t(1, 64'(n));
        end
        tick();
        wr_onehot = '0;
        #3;
        push("wrap_cnt_max", SRC_CNT, 64'hFFFF);
        push("wrap_reg1", SRC_A, 64'd65503);
        check_all();
        wr_t(1, 64'hCAFE);
        tick();
        wr_onehot = '0;
        #3;
        push("wrap_cnt_zero", SRC_CNT, {48'd0, exp_count});
        push("wrap_cnt_lit", SRC_CNT, 64'd0);
        push("wrap_err", SRC_ERR, 64'd0);
        push("wrap_reg1_last", SRC_A, 64'hCAFE);
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
